// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with input synchronizer, mid-bit sampling deframer and a
// first-word-fall-through receive FIFO with sticky framing/overrun flags.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT    = 868,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       RXD,
  input  logic                       RD_EN,
  output logic [7:0]                 RD_DATA,
  output logic                       EMPTY,
  output logic                       FULL,
  output logic [FIFO_DEPTH_LOG2:0]   COUNT,
  output logic                       FRAME_ERR,
  output logic                       OVERRUN,
  input  logic                       CLR_ERR,
  output logic                       BUSY
);

  localparam int AW    = FIFO_DEPTH_LOG2;
  localparam int DEPTH = 1 << AW;
  localparam int CW    = $clog2(CLKS_PER_BIT);

  typedef logic [CW-1:0] tick_t;
  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   lvl_t;

  localparam tick_t TICK_ZERO = tick_t'(0);
  localparam tick_t TICK_ONE  = tick_t'(1);
  localparam tick_t BIT_LAST  = tick_t'(CLKS_PER_BIT - 1);
  localparam tick_t HALF_LAST = tick_t'(CLKS_PER_BIT / 2 - 1);
  localparam ptr_t  PTR_ONE   = ptr_t'(1);
  localparam lvl_t  LVL_ZERO  = lvl_t'(0);
  localparam lvl_t  LVL_ONE   = lvl_t'(1);
  localparam lvl_t  LVL_FULL  = lvl_t'(DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_t;

  logic       rx_meta_r, rx_sync_r, rxs_s;
  state_t     state_r, state_nxt;
  tick_t      cnt_r, cnt_nxt;
  logic [2:0] bit_r, bit_nxt;
  logic [7:0] shift_r, shift_nxt;
  logic       push_r, push_nxt;
  logic [7:0] push_data_r;
  logic       ferr_set_s;

  logic [7:0] mem_r [DEPTH];
  ptr_t       rd_ptr_r, wr_ptr_r, rd_ptr_nxt, wr_ptr_nxt;
  lvl_t       count_r, count_nxt;
  logic [7:0] head_r, head_nxt;
  logic       empty_r, full_r, busy_r, frame_err_r, overrun_r;
  logic       do_pop_s, do_push_s, ovr_set_s;

  assign rxs_s = rx_sync_r;

  // Two-flop synchronizer for the asynchronous pad; idles high.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
    end else begin
      rx_meta_r <= RXD;
      rx_sync_r <= rx_meta_r;
    end
  end

  // Deframer next-state: cnt runs within each state and clears at each sample point.
  always_comb begin
    state_nxt  = state_r;
    cnt_nxt    = cnt_r + TICK_ONE;
    bit_nxt    = bit_r;
    shift_nxt  = shift_r;
    push_nxt   = 1'b0;
    ferr_set_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        cnt_nxt = TICK_ZERO;
        if (!rxs_s) state_nxt = ST_START;
        else        state_nxt = ST_IDLE;
      end
      ST_START: begin
        if (cnt_r == HALF_LAST) begin
          cnt_nxt = TICK_ZERO;
          bit_nxt = 3'd0;
          if (rxs_s) state_nxt = ST_IDLE;
          else       state_nxt = ST_DATA;
        end else begin
          state_nxt = ST_START;
        end
      end
      ST_DATA: begin
        if (cnt_r == BIT_LAST) begin
          cnt_nxt          = TICK_ZERO;
          shift_nxt[bit_r] = rxs_s;
          bit_nxt          = bit_r + 3'd1;
          if (bit_r == 3'd7) state_nxt = ST_STOP;
          else               state_nxt = ST_DATA;
        end else begin
          state_nxt = ST_DATA;
        end
      end
      ST_STOP: begin
        if (cnt_r == BIT_LAST) begin
          cnt_nxt = TICK_ZERO;
          if (rxs_s) begin
            push_nxt  = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            ferr_set_s = 1'b1;
            state_nxt  = ST_BREAK;
          end
        end else begin
          state_nxt = ST_STOP;
        end
      end
      ST_BREAK: begin
        cnt_nxt = TICK_ZERO;
        if (rxs_s) state_nxt = ST_IDLE;
        else       state_nxt = ST_BREAK;
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = TICK_ZERO;
      end
    endcase
  end

  // Deframer state registers; a reset mid-frame drops any pending push.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r     <= ST_IDLE;
      cnt_r       <= TICK_ZERO;
      bit_r       <= 3'd0;
      shift_r     <= 8'h00;
      push_r      <= 1'b0;
      push_data_r <= 8'h00;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt;
      cnt_r       <= cnt_nxt;
      bit_r       <= bit_nxt;
      shift_r     <= shift_nxt;
      push_r      <= push_nxt;
      push_data_r <= shift_nxt;
      busy_r      <= (state_nxt != ST_IDLE);
    end
  end

  // FIFO control; a push into a full FIFO survives only if a pop frees a slot the same cycle.
  always_comb begin
    do_pop_s   = RD_EN && (count_r != LVL_ZERO);
    do_push_s  = push_r && ((count_r != LVL_FULL) || do_pop_s);
    ovr_set_s  = push_r && (count_r == LVL_FULL) && !do_pop_s;
    rd_ptr_nxt = do_pop_s  ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
    wr_ptr_nxt = do_push_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
    case ({do_push_s, do_pop_s})
      2'b10:   count_nxt = count_r + LVL_ONE;
      2'b01:   count_nxt = count_r - LVL_ONE;
      default: count_nxt = count_r;
    endcase
    // Next head bypasses the memory when the incoming byte lands in the head slot.
    if (count_nxt == LVL_ZERO) begin
      head_nxt = 8'h00;
    end else if (do_push_s && (wr_ptr_r == rd_ptr_nxt)) begin
      head_nxt = push_data_r;
    end else begin
      head_nxt = mem_r[rd_ptr_nxt];
    end
  end

  // FIFO storage array.
  always_ff @(posedge CLK) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data_r;
    end
  end

  // FIFO pointers, level, registered head and sticky error flags (set beats clear).
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rd_ptr_r    <= ptr_t'(0);
      wr_ptr_r    <= ptr_t'(0);
      count_r     <= LVL_ZERO;
      head_r      <= 8'h00;
      empty_r     <= 1'b1;
      full_r      <= 1'b0;
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      rd_ptr_r <= rd_ptr_nxt;
      wr_ptr_r <= wr_ptr_nxt;
      count_r  <= count_nxt;
      head_r   <= head_nxt;
      empty_r  <= (count_nxt == LVL_ZERO);
      full_r   <= (count_nxt == LVL_FULL);
      if (ferr_set_s)   frame_err_r <= 1'b1;
      else if (CLR_ERR) frame_err_r <= 1'b0;
      else              frame_err_r <= frame_err_r;
      if (ovr_set_s)    overrun_r <= 1'b1;
      else if (CLR_ERR) overrun_r <= 1'b0;
      else              overrun_r <= overrun_r;
    end
  end

  assign RD_DATA   = head_r;
  assign EMPTY     = empty_r;
  assign FULL      = full_r;
  assign COUNT     = count_r;
  assign FRAME_ERR = frame_err_r;
  assign OVERRUN   = overrun_r;
  assign BUSY      = busy_r;

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Serial receive path for the board UART input pin. Oversamples the asynchronous RXD line, deframes 8N1 characters (LSB first), and buffers received bytes in a first-word-fall-through FIFO read by the SoC-side peripheral logic. Sits between the top-level UART input pad and the bus-facing UART register block, as the receive counterpart of the existing transmit path.

Parameters:
CLKS_PER_BIT, 868, CLK cycles per bit period (100 MHz / 115200); must be >= 4
FIFO_DEPTH_LOG2, 4, log2 of FIFO depth (default 16 entries)

Ports:
CLK  input  1  system clock
RST_N  input  1  asynchronous active-low reset
RXD  input  1  raw serial line, asynchronous, idle high
RD_EN  input  1  pop one byte from FIFO (ignored when EMPTY)
RD_DATA  output  8  head-of-FIFO byte, valid while EMPTY=0
EMPTY  output  1  FIFO holds no bytes
FULL  output  1  FIFO holds 2^FIFO_DEPTH_LOG2 bytes
COUNT  output  FIFO_DEPTH_LOG2+1  bytes currently stored
FRAME_ERR  output  1  sticky: stop bit sampled low
OVERRUN  output  1  sticky: valid byte dropped because FIFO full
CLR_ERR  input  1  clears FRAME_ERR and OVERRUN
BUSY  output  1  receiver not in IDLE

Behaviour:
- Reset (RST_N low, async): FSM=IDLE, FIFO pointers 0, COUNT=0, EMPTY=1, FULL=0, RD_DATA=0, FRAME_ERR=0, OVERRUN=0, BUSY=0; synchronizer flops preset to 1. Reset mid-frame abandons the frame; nothing is pushed.
- RXD passes through 2-flop synchronizer (reset value 1); all decisions use synchronized value rxs. Latency pad-to-rxs: 2 cycles.
- Bit counter cnt counts CLK cycles inside each state; mid-bit sample when cnt reaches target, then cnt clears.
- FSM:
  - IDLE: rxs==0 -> START, cnt=0.
  - START: at cnt==CLKS_PER_BIT/2-1 sample rxs; 1 -> IDLE (glitch, no error, no push); 0 -> DATA, bit index=0.
  - DATA: every CLKS_PER_BIT cycles sample rxs into shift register at bit index (LSB first); after bit 7 -> STOP.
  - STOP: after CLKS_PER_BIT cycles sample rxs. 1 -> push byte, -> IDLE. 0 -> set FRAME_ERR, discard byte, -> BREAK.
  - BREAK: wait until rxs==1, then -> IDLE (line held low never produces further bytes).
- BUSY=1 in every state except IDLE.
- Push occurs in the cycle after the stop-bit sample. Byte visible on RD_DATA with EMPTY=0 one cycle after push.
- FIFO: FWFT; RD_DATA always shows head entry. RD_EN with EMPTY=0 advances read pointer; next cycle shows next entry. RD_EN with EMPTY=1 has no effect.
- Push while FULL and no pop in same cycle: byte dropped, OVERRUN set, FIFO contents unchanged.
- Push and pop in same cycle: both take effect, COUNT unchanged; when FULL this is not an overrun.
- Pointers wrap modulo depth; COUNT is write-minus-read count, 0..2^FIFO_DEPTH_LOG2.
- CLR_ERR clears both sticky flags next cycle; if a set event coincides with CLR_ERR, set wins.
- Sampling point tolerates +/-4% baud mismatch with CLKS_PER_BIT>=16.

Test Plan:
- CLKS_PER_BIT=16: send 0x55 then 0xA3 at exact baud -> COUNT=2, RD_DATA=0x55; RD_EN one cycle -> RD_DATA=0xA3, COUNT=1; RD_EN again -> EMPTY=1.
- 4-cycle low glitch on idle RXD -> FSM returns IDLE, BUSY drops, COUNT stays 0, FRAME_ERR=0.
- Send 0x3C with stop bit driven low, line then held low 40 bit-times -> FRAME_ERR=1, COUNT=0, no bytes pushed; line high then send 0x81 -> RD_DATA=0x81; CLR_ERR -> FRAME_ERR=0.
- Send 17 bytes 0x00..0x10 with no reads, depth 16 -> FULL=1, COUNT=16, OVERRUN=1, draining yields 0x00..0x0F in order, 0x10 absent.
- FIFO full, assert RD_EN in exact push cycle of a 17th byte 0x77 -> OVERRUN=0, COUNT=16, 0x77 last on drain.
- Assert RST_N low mid-DATA of byte 0xF0 -> outputs at reset values immediately; after release, next byte 0x12 received correctly, 0xF0 never appears.
